alu_result_fifo: RTL and testbench
==================================

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of result entries; legal values are 2, 4, 8 and 16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the ALU result on in_y/in_s is presented for capture.
REQ-005 The block SHALL have port in_y, input, 8, the ALU result word.
REQ-006 The block SHALL have port in_s, input, 3, the ALU operation select that produced in_y.
REQ-007 The block SHALL have port in_ready, output, 1, high when an entry is free.
REQ-008 The block SHALL have port out_valid, output, 1, high when the head entry is valid.
REQ-009 The block SHALL have port out_y, output, 8, the head-entry result.
REQ-010 The block SHALL have port out_s, output, 3, the head-entry operation select.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the head entry.
REQ-012 The block SHALL have port count, output, log2(DEPTH)+1, the number of occupied entries.
REQ-013 The block SHALL have port drop_err, output, 1, a sticky flag set when a push is attempted while full.

Function
REQ-014 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1; {in_s,in_y} are written at the write pointer.
REQ-015 A pop SHALL occur on a rising edge where out_valid=1 and out_ready=1; the read pointer advances.
REQ-016 Storage SHALL be first-word-fall-through: out_y/out_s SHALL equal the head entry combinationally whenever out_valid=1.
REQ-017 Push-to-out_valid latency SHALL be 1 cycle from an empty FIFO.
REQ-018 in_ready SHALL be 1 when count<DEPTH; out_valid SHALL be 1 when count!=0; both are decoded from registered state only.
REQ-019 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without a gap.
REQ-020 count SHALL increment on push-only, decrement on pop-only, and stay unchanged on simultaneous push and pop.
REQ-021 When full with out_ready=1, a simultaneous pop and push SHALL not occur; in_ready stays 0 that cycle and the push is refused.
REQ-022 in_valid=1 while in_ready=0 SHALL leave storage unchanged and SHALL set drop_err on that edge.
REQ-023 Once set, drop_err SHALL remain 1 until rst.
REQ-024 A pop attempt while empty (out_ready=1, out_valid=0) SHALL have no effect.
REQ-025 out_y/out_s SHALL be 0 whenever out_valid=0.

Reset
REQ-026 On rst=1 at a rising edge, pointers and count SHALL become 0, drop_err 0, out_valid 0, in_ready 1, and out_y/out_s 0.
REQ-027 rst SHALL take priority over a simultaneous push or pop; an entry in flight mid-operation is discarded.
REQ-028 Storage array contents need not be cleared by rst.

Configuration
REQ-029 With macro ALU_RESULT_FLAGS_EN defined, the block SHALL add output out_zero (1 bit, out_y==0) and output out_par (1 bit, XOR of out_y).
REQ-030 With ALU_RESULT_FLAGS_EN defined, out_zero and out_par SHALL be computed at push time, stored per entry, and both be 0 when out_valid=0.
REQ-031 Without ALU_RESULT_FLAGS_EN, out_zero and out_par SHALL not exist, and entry width SHALL be 11 bits.

Verification
REQ-032 rst=1 for 2 cycles -> count=0, out_valid=0, in_ready=1, drop_err=0, out_y=0x00.
REQ-033 Push in_y=0x0C, in_s=000 with out_ready=0 -> next cycle out_valid=1, out_y=0x0C, out_s=000, count=1.
REQ-034 Push 0x01, 0x02, 0x03, 0x04 (DEPTH=4) with out_ready=0 -> count=4, in_ready=0; 5th push of 0x05 -> drop_err=1, and subsequent pops return 0x01..0x04 in order.
REQ-035 Push and pop in the same cycle with count=2 for 10 cycles using data 0x10..0x19 -> count stays 2, pointers wrap, and pop order matches push order.
REQ-036 Assert rst while count=3 with in_valid=1 -> next cycle count=0, out_valid=0, drop_err=0.
REQ-037 With ALU_RESULT_FLAGS_EN defined, push 0x00 then 0x07 -> head out_zero=1, out_par=0; after the pop, out_zero=0, out_par=1.

Source files
------------

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO holding ALU results {op select, result word}.
// Optional macro ALU_RESULT_FLAGS_EN adds per-entry zero/parity flags computed at push time.
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [7:0]                 in_y,
    input  logic [2:0]                 in_s,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_y,
    output logic [2:0]                 out_s,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
`ifdef ALU_RESULT_FLAGS_EN
    output logic                       out_zero,
    output logic                       out_par,
`endif
    output logic                       drop_err
);

    localparam int AW = $clog2(DEPTH);
`ifdef ALU_RESULT_FLAGS_EN
    localparam int EW = 13;
`else
    localparam int EW = 11;
`endif
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_drop_err;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_head;

    // Flow control decodes from the registered count only, so a full FIFO
    // refuses a push even while the consumer is draining that same cycle.
    assign w_full    = (r_count == CNT_FULL);
    assign in_ready  = ~w_full;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & ~w_full;
    assign w_pop     = out_valid & out_ready;

`ifdef ALU_RESULT_FLAGS_EN
    assign w_wr_entry = {^in_y, (in_y == 8'h00), in_s, in_y};
`else
    assign w_wr_entry = {in_s, in_y};
`endif

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        out_y = 8'h00;
        out_s = 3'b000;
`ifdef ALU_RESULT_FLAGS_EN
        out_zero = 1'b0;
        out_par  = 1'b0;
`endif
        if (out_valid) begin
            out_y = w_head[7:0];
            out_s = w_head[10:8];
`ifdef ALU_RESULT_FLAGS_EN
            out_zero = w_head[11];
            out_par  = w_head[12];
`endif
        end
    end

    // Storage is deliberately not reset; the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (in_valid && w_full) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign count    = r_count;
    assign drop_err = r_drop_err;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo (DEPTH=4): reset, FWFT latency, full/drop,
// steady push+pop wrap, reset mid-operation, and optional flag outputs.
module tb_alu_result_fifo;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_y;
    logic [2:0] in_s;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_y;
    logic [2:0] out_s;
    logic       out_ready;
    logic [2:0] count;
    logic       drop_err;
`ifdef ALU_RESULT_FLAGS_EN
    logic       out_zero;
    logic       out_par;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];

    alu_result_fifo #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_y      (in_y),
        .in_s      (in_s),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_y     (out_y),
        .out_s     (out_s),
        .out_ready (out_ready),
        .count     (count),
`ifdef ALU_RESULT_FLAGS_EN
        .out_zero  (out_zero),
        .out_par   (out_par),
`endif
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Push one word into a FIFO the bench knows has room.
    task automatic push(input logic [7:0] y, input logic [2:0] s);
        in_valid = 1'b1;
        in_y     = y;
        in_s     = s;
        tick();
        in_valid = 1'b0;
        exp_q.push_back({s, y});
    endtask

    // Compare the head against the model, then pop it.
    task automatic pop_check(input string tag);
        logic [10:0] e;
        e = exp_q.pop_front();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_y"}, 32'(out_y), 32'(e[7:0]));
        check({tag, "_s"}, 32'(out_s), 32'(e[10:8]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_y      = 8'h00;
        in_s      = 3'b000;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_drop_err", 32'(drop_err), 32'd0);
        check("rst_out_y", 32'(out_y), 32'h00);
        check("rst_out_s", 32'(out_s), 32'h0);

        // Single push: visible one cycle later.
        push(8'h0C, 3'b000);
        check("one_count", 32'(count), 32'd1);
        pop_check("one");
        check("one_empty_valid", 32'(out_valid), 32'd0);
        check("one_empty_y", 32'(out_y), 32'h00);

        // Pop attempt while empty.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("empty_pop_count", 32'(count), 32'd0);
        check("empty_pop_ready", 32'(in_ready), 32'd1);

        // Fill to DEPTH.
        for (int i = 1; i <= 4; i++) push(8'(i), 3'(i + 2));
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_drop_err", 32'(drop_err), 32'd0);
        check("full_head", 32'(out_y), 32'h01);

        // Push 0x05 while full with out_ready=1: pop happens, push refused.
        in_valid  = 1'b1;
        in_y      = 8'h05;
        in_s      = 3'b111;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        check("drop_err_set", 32'(drop_err), 32'd1);
        check("drop_count", 32'(count), 32'd3);
        check("drop_head", 32'(out_y), 32'h02);
        pop_check("drain2");
        pop_check("drain3");
        pop_check("drain4");
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drop_sticky", 32'(drop_err), 32'd1);

        // Steady push+pop at count=2, pointers wrap several times.
        push(8'h10, 3'b001);
        push(8'h11, 3'b010);
        for (int i = 0; i < 10; i++) begin
            logic [10:0] e;
            e = exp_q[0];
            check("steady_count", 32'(count), 32'd2);
            check("steady_y", 32'(out_y), 32'(e[7:0]));
            check("steady_s", 32'(out_s), 32'(e[10:8]));
            in_valid  = 1'b1;
            in_y      = 8'(8'h12 + i);
            in_s      = 3'(i);
            out_ready = 1'b1;
            tick();
            exp_q.push_back({in_s, in_y});
            void'(exp_q.pop_front());
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("steady_end_count", 32'(count), 32'd2);
        pop_check("steady_drain_a");
        pop_check("steady_drain_b");

        // Reset mid-operation with a push in flight.
        push(8'hA1, 3'b001);
        push(8'hA2, 3'b010);
        push(8'hA3, 3'b011);
        check("pre_rst_count", 32'(count), 32'd3);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_y     = 8'hA4;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_drop", 32'(drop_err), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_y", 32'(out_y), 32'h00);

`ifdef ALU_RESULT_FLAGS_EN
        check("flag_empty_zero", 32'(out_zero), 32'd0);
        check("flag_empty_par", 32'(out_par), 32'd0);
        push(8'h00, 3'b000);
        push(8'h07, 3'b001);
        check("flag_zero_a", 32'(out_zero), 32'd1);
        check("flag_par_a", 32'(out_par), 32'd0);
        pop_check("flag_pop_a");
        check("flag_zero_b", 32'(out_zero), 32'd0);
        check("flag_par_b", 32'(out_par), 32'd1);
        pop_check("flag_pop_b");
        check("flag_after_zero", 32'(out_zero), 32'd0);
        check("flag_after_par", 32'(out_par), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
